// File: rtl/ddr3_axi_cmd_arbiter_pkg.sv
// Shared types for the DDR3 burst-engine command arbiter: FSM states and ID-width helper.
package ddr3_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  // Width of a requester index; never narrower than one bit.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ddr3_axi_cmd_arbiter_if.sv
// Requester-side and engine-side command/completion bundle of the arbiter.
// master = arbiter view, slave = traffic sources plus burst engine.
interface ddr3_axi_cmd_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
);
  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0]                 req_ready;
  logic [NUM_REQ-1:0]                 req_we;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0][LEN_WIDTH-1:0]  req_len;
  logic [NUM_REQ-1:0]                 req_done;
  logic [NUM_REQ-1:0]                 req_error;

  logic                  eng_valid;
  logic                  eng_ready;
  logic                  eng_we;
  logic [ADDR_WIDTH-1:0] eng_addr;
  logic [LEN_WIDTH-1:0]  eng_len;
  logic                  eng_done;
  logic                  eng_error;

  modport master (
    input  req_valid, req_we, req_addr, req_len, eng_ready, eng_done, eng_error,
    output req_ready, req_done, req_error, eng_valid, eng_we, eng_addr, eng_len
  );

  modport slave (
    output req_valid, req_we, req_addr, req_len, eng_ready, eng_done, eng_error,
    input  req_ready, req_done, req_error, eng_valid, eng_we, eng_addr, eng_len
  );
endinterface

// File: rtl/ddr3_axi_cmd_arbiter_rr_picker.sv
// Combinational round-robin priority encoder: first set request strictly after
// last_grant, wrapping to index 0.
module ddr3_rr_picker
  import ddr3_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = id_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     last_grant,
  output logic               vld,
  output logic [IDW-1:0]     idx
);

  logic found;
  int   k;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    k     = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      k = (int'(last_grant) + i) % NUM_REQ;
      if (!found && req[k]) begin
        found = 1'b1;
        idx   = IDW'(k);
      end
    end
    vld = found;
  end

endmodule

// File: rtl/ddr3_axi_cmd_arbiter.sv
// Round-robin arbiter sharing one DDR3 AXI burst engine between NUM_REQ requesters.
// Optional watchdog on the WAIT state: define DDR3_ARB_WATCHDOG_EN.
module ddr3_axi_cmd_arbiter
  import ddr3_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int LEN_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  ddr3_axi_cmd_arbiter_if.master    bus,
  output logic                      busy,
  output logic [id_w(NUM_REQ)-1:0]  grant_id,
  output logic                      timeout_err
);

  localparam int IDW = id_w(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("ddr3_axi_cmd_arbiter: NUM_REQ must be 2..8");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("ddr3_axi_cmd_arbiter: TIMEOUT_CYCLES must be >= 2");
  end

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]  len;
  } cmd_t;

  arb_state_e         state_q, state_d;
  logic [IDW-1:0]     grant_q, grant_d;
  logic [IDW-1:0]     last_q,  last_d;
  cmd_t               cmd_q,   cmd_d;
  logic [NUM_REQ-1:0] done_q,  done_d;
  logic [NUM_REQ-1:0] err_q,   err_d;

  logic               pick_vld;
  logic [IDW-1:0]     pick_idx;

`ifdef DDR3_ARB_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tmo_q, tmo_d;
`endif

  ddr3_rr_picker #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_picker (
    .req        (bus.req_valid),
    .last_grant (last_q),
    .vld        (pick_vld),
    .idx        (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cmd_d   = cmd_q;
    done_d  = '0;
    err_d   = '0;
`ifdef DDR3_ARB_WATCHDOG_EN
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d = pick_idx;
          cmd_d   = '{we:   bus.req_we[pick_idx],
                      addr: bus.req_addr[pick_idx],
                      len:  bus.req_len[pick_idx]};
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.eng_ready) begin
          state_d = WAIT;
`ifdef DDR3_ARB_WATCHDOG_EN
          cnt_d   = '0;
`endif
        end
      end
      WAIT: begin
        if (bus.eng_done) begin
          done_d[grant_q] = 1'b1;
          err_d[grant_q]  = bus.eng_error;
          last_d          = grant_q;
          state_d         = IDLE;
        end
`ifdef DDR3_ARB_WATCHDOG_EN
        // Engine never answered: report a failed burst so the owner is released.
        else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          done_d[grant_q] = 1'b1;
          err_d[grant_q]  = 1'b1;
          tmo_d           = 1'b1;
          last_d          = grant_q;
          state_d         = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IDW'(NUM_REQ - 1);
      cmd_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
`ifdef DDR3_ARB_WATCHDOG_EN
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cmd_q   <= cmd_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef DDR3_ARB_WATCHDOG_EN
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

  // Accept pulse follows eng_ready combinationally so the requester can drop valid next edge.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_ready
    assign bus.req_ready[i] = (state_q == ISSUE) && bus.eng_ready && (grant_q == IDW'(i));
  end

  assign bus.eng_valid = (state_q == ISSUE);
  assign bus.eng_we    = cmd_q.we;
  assign bus.eng_addr  = cmd_q.addr;
  assign bus.eng_len   = cmd_q.len;
  assign bus.req_done  = done_q;
  assign bus.req_error = err_q;
  assign busy          = (state_q != IDLE);
  assign grant_id      = grant_q;

`ifdef DDR3_ARB_WATCHDOG_EN
  assign timeout_err = tmo_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_ddr3_axi_cmd_arbiter.sv
// Bench for ddr3_axi_cmd_arbiter: vector table, directed corner sequences and a
// randomized run against a transaction-level round-robin model.
module tb_ddr3_axi_cmd_arbiter;

  localparam int N   = 4;
  localparam int AW  = 32;
  localparam int LW  = 8;
  localparam int TO  = 16;
  localparam int IDW = 2;

  logic ACLK = 1'b0;
  logic ARESETN;
  logic busy;
  logic [IDW-1:0] grant_id;
  logic timeout_err;

  always #5 ACLK = ~ACLK;

  ddr3_axi_cmd_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

  ddr3_axi_cmd_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .ACLK        (ACLK),
    .ARESETN     (ARESETN),
    .bus         (bus),
    .busy        (busy),
    .grant_id    (grant_id),
    .timeout_err (timeout_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic drive_idle();
    bus.req_valid = '0;
    bus.eng_ready = 1'b0;
    bus.eng_done  = 1'b0;
    bus.eng_error = 1'b0;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_ready"}, 64'(bus.req_ready), 64'(0));
    chk({nm, "_done"},  64'(bus.req_done),  64'(0));
    chk({nm, "_err"},   64'(bus.req_error), 64'(0));
    chk({nm, "_evld"},  64'(bus.eng_valid), 64'(0));
    chk({nm, "_ewe"},   64'(bus.eng_we),    64'(0));
    chk({nm, "_eaddr"}, 64'(bus.eng_addr),  64'(0));
    chk({nm, "_elen"},  64'(bus.eng_len),   64'(0));
    chk({nm, "_busy"},  64'(busy),          64'(0));
    chk({nm, "_gid"},   64'(grant_id),      64'(0));
    chk({nm, "_tmo"},   64'(timeout_err),   64'(0));
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++)
      if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  typedef struct {
    logic [N-1:0]   v;
    logic           rdy, dn, er;
    logic [N-1:0]   x_rdy;
    logic           x_vld, x_busy;
    logic [IDW-1:0] x_gid;
    logic [N-1:0]   x_done, x_err;
  } vec_t;

  vec_t tbl[15];

  // Transaction-level model state for the random run
  int             m_ph;   // 0 free, 1 offered to engine, 2 engine owns it
  int             m_owner, m_last, wcnt;
  logic [AW-1:0]  m_addr;
  logic [LW-1:0]  m_len;
  logic           m_we;
  logic [N-1:0]   x_done, x_err, x_rdy, pend, acc;
  int             seen;

  initial begin
    int order [5];
    order = '{0, 1, 2, 3, 0};

    // Table: all four requesting, zero-latency engine, requester 2 fails.
    for (int k = 0; k < 5; k++) begin
      logic [N-1:0] oh;
      oh = '0;
      oh[order[k]] = 1'b1;
      for (int r = 0; r < 3; r++) begin
        tbl[3*k+r].v      = 4'hF;
        tbl[3*k+r].rdy    = 1'b1;
        tbl[3*k+r].dn     = (r == 2);
        tbl[3*k+r].er     = (r == 2) && (k == 2);
        tbl[3*k+r].x_rdy  = (r == 1) ? oh : '0;
        tbl[3*k+r].x_vld  = (r == 0);
        tbl[3*k+r].x_busy = (r != 2);
        tbl[3*k+r].x_gid  = IDW'(order[k]);
        tbl[3*k+r].x_done = (r == 2) ? oh : '0;
        tbl[3*k+r].x_err  = (r == 2 && k == 2) ? oh : '0;
      end
    end

    for (int i = 0; i < N; i++) begin
      bus.req_addr[i] = AW'(32'h100 * (i + 1));
      bus.req_we[i]   = i[0];
      bus.req_len[i]  = LW'(i + 3);
    end
    drive_idle();

    // Reset state
    ARESETN = 1'b0;
    repeat (3) tick();
    chk_all_zero("reset");
    ARESETN = 1'b1;
    tick();
    chk_all_zero("post_reset");

    for (int r = 0; r < 15; r++) begin
      bus.req_valid = tbl[r].v;
      bus.eng_ready = tbl[r].rdy;
      bus.eng_done  = tbl[r].dn;
      bus.eng_error = tbl[r].er;
      #2;
      chk($sformatf("tbl%0d_ready", r), 64'(bus.req_ready), 64'(tbl[r].x_rdy));
      tick();
      chk($sformatf("tbl%0d_evld", r), 64'(bus.eng_valid), 64'(tbl[r].x_vld));
      chk($sformatf("tbl%0d_busy", r), 64'(busy),          64'(tbl[r].x_busy));
      chk($sformatf("tbl%0d_gid", r),  64'(grant_id),      64'(tbl[r].x_gid));
      chk($sformatf("tbl%0d_done", r), 64'(bus.req_done),  64'(tbl[r].x_done));
      chk($sformatf("tbl%0d_err", r),  64'(bus.req_error), 64'(tbl[r].x_err));
      if (tbl[r].x_vld)
        chk($sformatf("tbl%0d_addr", r), 64'(bus.eng_addr), 64'(32'h100 * (tbl[r].x_gid + 1)));
    end
    drive_idle();
    tick();

    // Single write from requester 0, done 20 cycles after acceptance
    bus.req_addr[0] = 32'h0000_1000;
    bus.req_len[0]  = 8'd15;
    bus.req_we[0]   = 1'b1;
    bus.req_valid   = 4'b0001;
    bus.eng_ready   = 1'b1;
    tick();
    chk("s1_evld", 64'(bus.eng_valid), 64'(1));
    chk("s1_addr", 64'(bus.eng_addr),  64'(32'h1000));
    chk("s1_len",  64'(bus.eng_len),   64'(15));
    chk("s1_we",   64'(bus.eng_we),    64'(1));
    chk("s1_gid",  64'(grant_id),      64'(0));
    #2;
    chk("s1_ready", 64'(bus.req_ready), 64'(4'b0001));
    tick();
    bus.req_valid = '0;
    acc = '0;
    for (int c = 0; c < 19; c++) begin
      #2;
      acc |= bus.req_ready | bus.req_done;
      tick();
    end
    chk("s1_no_extra_pulse", 64'(acc), 64'(0));
    chk("s1_busy_wait", 64'(busy), 64'(1));
    bus.eng_done = 1'b1;
    tick();
    bus.eng_done = 1'b0;
    chk("s1_done", 64'(bus.req_done),  64'(4'b0001));
    chk("s1_err",  64'(bus.req_error), 64'(0));
    chk("s1_busy", 64'(busy),          64'(0));
    tick();
    chk("s1_done_pulse", 64'(bus.req_done), 64'(0));

    // Engine stalls 10 cycles: command held, no accept pulse
    bus.req_addr[1] = 32'hABCD_0000;
    bus.req_valid   = 4'b0010;
    bus.eng_ready   = 1'b0;
    tick();
    acc = '0;
    for (int c = 0; c < 10; c++) begin
      #2;
      acc |= bus.req_ready;
      chk("s2_evld", 64'(bus.eng_valid), 64'(1));
      chk("s2_addr", 64'(bus.eng_addr),  64'(32'hABCD_0000));
      tick();
    end
    chk("s2_no_ready", 64'(acc), 64'(0));
    bus.eng_ready = 1'b1;
    #2;
    chk("s2_ready", 64'(bus.req_ready), 64'(4'b0010));
    tick();
    drive_idle();
    bus.eng_done = 1'b1;
    tick();
    bus.eng_done = 1'b0;
    chk("s2_done", 64'(bus.req_done), 64'(4'b0010));
    tick();

    // Reset in WAIT, then requester 0 wins over 2
    bus.req_valid = 4'b0100;
    bus.eng_ready = 1'b1;
    tick();
    tick();
    drive_idle();
    chk("s3_busy_wait", 64'(busy), 64'(1));
    ARESETN = 1'b0;
    #1;
    chk_all_zero("s3_async");
    tick();
    ARESETN = 1'b1;
    bus.req_valid = 4'b0101;
    bus.eng_ready = 1'b1;
    tick();
    chk("s3_gid",  64'(grant_id),     64'(0));
    chk("s3_addr", 64'(bus.eng_addr), 64'(32'h1000));
    #2;
    chk("s3_ready", 64'(bus.req_ready), 64'(4'b0001));
    tick();
    drive_idle();
    bus.eng_done = 1'b1;
    tick();
    bus.eng_done = 1'b0;
    chk("s3_done", 64'(bus.req_done), 64'(4'b0001));
    tick();

    // Randomized run against the model, from a clean reset
    ARESETN = 1'b0;
    tick();
    ARESETN = 1'b1;
    m_ph = 0; m_owner = 0; m_last = N - 1; wcnt = 0;
    m_addr = '0; m_len = '0; m_we = 1'b0;
    x_done = '0; x_err = '0; pend = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      chk("rnd_busy", 64'(busy),          64'(m_ph != 0));
      chk("rnd_evld", 64'(bus.eng_valid), 64'(m_ph == 1));
      chk("rnd_gid",  64'(grant_id),      64'(m_owner));
      chk("rnd_addr", 64'(bus.eng_addr),  64'(m_addr));
      chk("rnd_len",  64'(bus.eng_len),   64'(m_len));
      chk("rnd_we",   64'(bus.eng_we),    64'(m_we));
      chk("rnd_done", 64'(bus.req_done),  64'(x_done));
      chk("rnd_err",  64'(bus.req_error), 64'(x_err));

      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i]         = 1'b1;
          bus.req_addr[i] = AW'($urandom());
          bus.req_len[i]  = LW'($urandom_range(0, 255));
          bus.req_we[i]   = 1'($urandom_range(0, 1));
        end
      end
      bus.req_valid = pend;
      bus.eng_ready = ($urandom_range(0, 2) != 0);
      bus.eng_error = ($urandom_range(0, 3) == 0);
      if (m_ph == 2) bus.eng_done = ($urandom_range(0, 3) == 0) || (wcnt >= 8);
      else           bus.eng_done = (m_ph == 1) && ($urandom_range(0, 7) == 0);
      #2;
      x_rdy = '0;
      if (m_ph == 1 && bus.eng_ready) x_rdy[m_owner] = 1'b1;
      chk("rnd_ready", 64'(bus.req_ready), 64'(x_rdy));

      x_done = '0;
      x_err  = '0;
      case (m_ph)
        0: if (|bus.req_valid) begin
             m_owner = rr_pick(bus.req_valid, m_last);
             m_addr  = bus.req_addr[m_owner];
             m_len   = bus.req_len[m_owner];
             m_we    = bus.req_we[m_owner];
             m_ph    = 1;
           end
        1: if (bus.eng_ready) begin
             pend[m_owner] = 1'b0;
             m_ph = 2;
             wcnt = 0;
           end
        default: if (bus.eng_done) begin
             x_done[m_owner] = 1'b1;
             x_err[m_owner]  = bus.eng_error;
             m_last = m_owner;
             m_ph   = 0;
           end else wcnt++;
      endcase
      tick();
    end
    drive_idle();
    // Let any open transaction finish so the next sequence starts idle
    for (int c = 0; c < 4; c++) begin
      bus.eng_ready = 1'b1;
      bus.eng_done  = 1'b1;
      tick();
    end
    drive_idle();
    tick();
    chk("rnd_drain_busy", 64'(busy), 64'(0));

    // Engine never completes: watchdog releases, or plain build holds in WAIT
    bus.req_valid = 4'b1000;
    bus.eng_ready = 1'b1;
    tick();
    tick();
    drive_idle();
`ifdef DDR3_ARB_WATCHDOG_EN
    seen = 0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (seen == 0 && bus.req_done != '0) begin
        seen = n;
        chk("wd_done", 64'(bus.req_done),  64'(4'b1000));
        chk("wd_err",  64'(bus.req_error), 64'(4'b1000));
      end
    end
    chk("wd_latency", 64'(seen), 64'(TO));
    chk("wd_tmo", 64'(timeout_err), 64'(1));
    bus.eng_done = 1'b1;
    tick();
    bus.eng_done = 1'b0;
    tick();
    chk("wd_late_done_ignored", 64'(bus.req_done), 64'(0));
    chk("wd_tmo_sticky", 64'(timeout_err), 64'(1));
    chk("wd_idle", 64'(busy), 64'(0));
`else
    acc = '0;
    for (int n = 0; n < 40; n++) begin
      tick();
      acc |= bus.req_done;
    end
    chk("hold_no_done", 64'(acc), 64'(0));
    chk("hold_busy", 64'(busy), 64'(1));
    chk("hold_tmo", 64'(timeout_err), 64'(0));
    bus.eng_done = 1'b1;
    tick();
    bus.eng_done = 1'b0;
    chk("hold_done", 64'(bus.req_done),  64'(4'b1000));
    chk("hold_err",  64'(bus.req_error), 64'(0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
